// File: rtl/multi_cycle_fsm.sv
// Control unit for a multi-cycle CPU datapath.
// Walks each instruction through fetch, decode, execute, memory and writeback,
// and drives the datapath enables as pure decodes of the current state and opcode.
// The enables never lag the state by a cycle.
// The machine stays in sHALT until Reset is asserted.
module multi_cycle_fsm #(
    parameter logic [5:0] HALT_OP = 6'b111111
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic [3:0] state,
    output logic       PCWre,
    output logic [1:0] PCSrc,
    output logic       IRWre,
    output logic       RegWre,
    output logic       mRD,
    output logic       mWR,
    output logic       ALUSrcB,
    output logic       DBDataSrc,
    output logic       halted
);

    typedef enum logic [3:0] {
        S_IF     = 4'd0,
        S_ID     = 4'd1,
        S_EXE_AL = 4'd2,
        S_WB_AL  = 4'd3,
        S_EXE_BR = 4'd4,
        S_EXE_LS = 4'd5,
        S_MEM    = 4'd6,
        S_WB_LD  = 4'd7,
        S_HALT   = 4'd8
    } state_t;

    state_t cur;

    logic is_halt;
    logic is_rtype;
    logic is_addi;
    logic is_sw;
    logic is_lw;
    logic is_beq;
    logic is_j;

    assign state = cur;

    // Opcode class decode; the halt opcode takes priority so HALT_OP may overlap any class.
    always_comb begin
        is_halt  = 1'b0;
        is_rtype = 1'b0;
        is_addi  = 1'b0;
        is_sw    = 1'b0;
        is_lw    = 1'b0;
        is_beq   = 1'b0;
        is_j     = 1'b0;
        if (opcode == HALT_OP) begin
            is_halt = 1'b1;
        end else begin
            case (opcode)
                6'b000000: is_rtype = 1'b1;
                6'b000001: is_addi  = 1'b1;
                6'b110000: is_sw    = 1'b1;
                6'b110001: is_lw    = 1'b1;
                6'b110100: is_beq   = 1'b1;
                6'b111000: is_j     = 1'b1;
                default:   ;
            endcase
        end
    end

    // State register and next-state selection; unused encodings fall back to fetch.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            cur <= S_IF;
        end else begin
            case (cur)
                S_IF: cur <= S_ID;
                S_ID: begin
                    if (is_halt)                cur <= S_HALT;
                    else if (is_rtype || is_addi) cur <= S_EXE_AL;
                    else if (is_lw || is_sw)    cur <= S_EXE_LS;
                    else if (is_beq)            cur <= S_EXE_BR;
                    else                        cur <= S_IF;
                end
                S_EXE_AL: cur <= S_WB_AL;
                S_WB_AL:  cur <= S_IF;
                S_EXE_BR: cur <= S_IF;
                S_EXE_LS: cur <= S_MEM;
                S_MEM:    cur <= is_lw ? S_WB_LD : S_IF;
                S_WB_LD:  cur <= S_IF;
                S_HALT:   cur <= S_HALT;
                default:  cur <= S_IF;
            endcase
        end
    end

    // Datapath enables decoded from the current state; PCSrc is also steered by zero in sEXE_BR.
    always_comb begin
        PCWre     = 1'b0;
        PCSrc     = 2'b00;
        IRWre     = 1'b0;
        RegWre    = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        ALUSrcB   = 1'b0;
        DBDataSrc = 1'b0;
        halted    = 1'b0;
        case (cur)
            S_IF: IRWre = 1'b1;
            S_ID: begin
                if (is_j) begin
                    PCWre = 1'b1;
                    PCSrc = 2'b11;
                end else if (!(is_halt || is_rtype || is_addi || is_lw || is_sw || is_beq)) begin
                    PCWre = 1'b1;
                end
            end
            S_EXE_AL: ALUSrcB = is_addi;
            S_WB_AL: begin
                RegWre = 1'b1;
                PCWre  = 1'b1;
            end
            S_EXE_BR: begin
                PCWre = 1'b1;
                PCSrc = zero ? 2'b01 : 2'b00;
            end
            S_EXE_LS: ALUSrcB = 1'b1;
            S_MEM: begin
                mRD   = is_lw;
                mWR   = is_sw;
                PCWre = !is_lw;
            end
            S_WB_LD: begin
                RegWre    = 1'b1;
                DBDataSrc = 1'b1;
                PCWre     = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/multi_cycle_fsm.md
MULTI_CYCLE_FSM -- requirements
Module: multi_cycle_fsm

Interface
REQ-001 The block SHALL have parameter HALT_OP, default 6'b111111, meaning the opcode that stops the machine.
REQ-002 The block SHALL have port CLK  input  1  single clock; all state changes occur on the rising edge.
REQ-003 The block SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port opcode  input  6  IR[31:26], stable from the cycle after IRWre.
REQ-005 The block SHALL have port zero  input  1  ALU zero flag, valid in the EXE cycle.
REQ-006 The block SHALL have port state  output  4  current state encoding, for debug.
REQ-007 The block SHALL have port PCWre  output  1  PC load enable for this edge.
REQ-008 The block SHALL have port PCSrc  output  2  next-PC select: 00 PC+4, 01 branch target, 11 jump target.
REQ-009 The block SHALL have port IRWre  output  1  instruction register load enable.
REQ-010 The block SHALL have port RegWre  output  1  register-file write enable.
REQ-011 The block SHALL have port mRD  output  1  data memory read enable.
REQ-012 The block SHALL have port mWR  output  1  data memory write enable.
REQ-013 The block SHALL have port ALUSrcB  output  1  ALU B operand select: 0 register (BDR), 1 sign-extended immediate.
REQ-014 The block SHALL have port DBDataSrc  output  1  writeback select: 0 ALU result, 1 memory data.
REQ-015 The block SHALL have port halted  output  1  high while in sHALT.

Function
REQ-016 State encodings SHALL be: sIF=0, sID=1, sEXE_AL=2, sWB_AL=3, sEXE_BR=4, sEXE_LS=5, sMEM=6, sWB_LD=7, sHALT=8; codes 9-15 SHALL go to sIF on the next edge.
REQ-017 Opcode classes SHALL be: R-type 000000, addi 000001, sw 110000, lw 110001, beq 110100, j 111000, halt = HALT_OP; any other opcode is a NOP.
REQ-018 Transitions SHALL be:
- sIF -> sID
- sID -> sEXE_AL (R-type or addi), sEXE_LS (lw or sw), sEXE_BR (beq), sHALT (halt), sIF (j or NOP)
- sEXE_AL -> sWB_AL -> sIF
- sEXE_BR -> sIF
- sEXE_LS -> sMEM
- sMEM -> sWB_LD (lw), sIF (sw)
- sWB_LD -> sIF
- sHALT -> sHALT
REQ-019 All outputs SHALL be Moore/Mealy combinational decodes of state and opcode; no output SHALL lag the state by a cycle.
REQ-020 IRWre SHALL be 1 only in sIF.
REQ-021 PCWre SHALL be 1 exactly once per instruction, on its last cycle: sID for j or NOP, sEXE_BR, sMEM for sw, sWB_AL, sWB_LD; it SHALL be 0 in all other cycles, including every cycle in sHALT.
REQ-022 PCSrc SHALL be:
- 11 in sID for j
- 01 in sEXE_BR when zero=1
- 00 in all other cycles
REQ-023 ALUSrcB SHALL be 1 in sEXE_AL for addi and in sEXE_LS, and 0 otherwise.
REQ-024 mRD SHALL be 1 only in sMEM for lw, and mWR SHALL be 1 only in sMEM for sw; the two SHALL never be high together.
REQ-025 RegWre SHALL be 1 only in sWB_AL and sWB_LD; DBDataSrc SHALL be 1 only in sWB_LD.
REQ-026 Instruction latencies in cycles SHALL be: j/NOP 2, beq 3, R/addi 4, sw 4, lw 5.
REQ-027 halted SHALL be 1 exactly when state=sHALT; only Reset SHALL exit sHALT.

Reset
REQ-028 When Reset=0, state SHALL go to sIF immediately, without waiting for a clock edge.
REQ-029 While state=sIF after reset, outputs SHALL be: IRWre=1, all other enables 0, PCSrc=00, halted=0.
REQ-030 Reset asserted mid-instruction SHALL abort the instruction; no RegWre, mWR or PCWre pulse SHALL occur after Reset falls.
REQ-031 The first rising CLK edge after Reset rises SHALL move sIF to sID.

Verification
REQ-032 Scenario 1: release reset with opcode=000000 -> states 0,1,2,3,0; RegWre=1 and PCWre=1 only in cycle 4; ALUSrcB=0.
REQ-033 Scenario 2: lw (110001) -> states 0,1,5,6,7,0; mRD=1 in state 6; RegWre=1, DBDataSrc=1 and PCWre=1 in state 7.
REQ-034 Scenario 3: sw (110000) -> states 0,1,5,6,0; mWR=1 and PCWre=1 in state 6; RegWre never 1.
REQ-035 Scenario 4: beq (110100) with zero=1 -> PCSrc=01 and PCWre=1 in state 4; repeat with zero=0 -> PCSrc=00 and PCWre=1.
REQ-036 Scenario 5: j (111000) -> PCSrc=11 and PCWre=1 in state 1, next state 0; then opcode 111111 -> state 8, halted=1, PCWre=0 for 10 cycles.
REQ-037 Scenario 6: drive Reset=0 between clock edges while in state 6 during a sw -> state=0 at once and mWR=0; unknown opcode 101010 -> states 0,1,0 with PCWre=1 in state 1.
